// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan test controller: chain geometry, FSM encoding, latched test vector.
package scan_ctrl_pkg;

  localparam int unsigned CHAIN_LEN  = 8;
  localparam int unsigned CNT_W      = $clog2(CHAIN_LEN);
  localparam int unsigned FAIL_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expected;
  } test_vec_t;

endpackage

// File: rtl/scan_test_controller_if.sv
// Test-host and scan-chain signals of the scan test controller; slave = controller side.
// Carries fail_cnt only when SCAN_FAIL_CNT_EN is defined.
interface scan_test_controller_if;
  import scan_ctrl_pkg::*;

  logic                 start;
  logic [CHAIN_LEN-1:0] pattern;
  logic [CHAIN_LEN-1:0] expected;
  logic                 scan_out;
  logic                 scan_in;
  logic                 scan_en;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] response;
`ifdef SCAN_FAIL_CNT_EN
  logic [FAIL_CNT_W-1:0] fail_cnt;

  modport master (output start, pattern, expected, scan_out,
                  input  scan_in, scan_en, busy, done, pass, response, fail_cnt);
  modport slave  (input  start, pattern, expected, scan_out,
                  output scan_in, scan_en, busy, done, pass, response, fail_cnt);
`else
  modport master (output start, pattern, expected, scan_out,
                  input  scan_in, scan_en, busy, done, pass, response);
  modport slave  (input  start, pattern, expected, scan_out,
                  output scan_in, scan_en, busy, done, pass, response);
`endif

endinterface

// File: rtl/scan_bit_counter.sv
// Shift-position counter shared by the LOAD and UNLOAD phases; flags the last position.
module scan_bit_counter #(
  parameter int unsigned      CNT_W = 3,
  parameter logic [CNT_W-1:0] LAST  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             term_c
);

  assign term_c = (cnt == LAST);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= term_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scan_test_controller.sv
// Scan test sequencer: shift pattern in, one capture cycle, shift response out, compare.
// Optional saturating fail counter enabled by defining SCAN_FAIL_CNT_EN. rst_n is active-high.
module scan_test_controller
  import scan_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  scan_test_controller_if.slave bus
);

  localparam int unsigned N = CHAIN_LEN;

  state_e           state_q;
  state_e           state_d;
  test_vec_t        vec_q;
  logic [N-2:0]     resp_sh_q;
  logic [N-1:0]     resp_next_c;
  logic [N-1:0]     response_q;
  logic             pass_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_term;
  logic             cnt_clr;
  logic             cnt_en;
  logic             accept_c;
  logic             unload_last_c;

  scan_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (CNT_W'(N - 1))
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (cnt),
    .term_c (cnt_term)
  );

  assign accept_c      = (state_q == ST_IDLE) && bus.start;
  assign unload_last_c = (state_q == ST_UNLOAD) && cnt_term;
  // Chain tail enters at the MSB so the first bit out lands at bit 0 after N shifts.
  assign resp_next_c   = {bus.scan_out, resp_sh_q};

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_LOAD;
      ST_LOAD:    if (cnt_term)  state_d = ST_CAPTURE;
      ST_CAPTURE:                state_d = ST_UNLOAD;
      ST_UNLOAD:  if (cnt_term)  state_d = ST_DONE;
      ST_DONE:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Output and counter-control decode from registered state
  always_comb begin
    bus.scan_en = 1'b0;
    bus.scan_in = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        bus.scan_en = 1'b1;
        bus.scan_in = vec_q.pattern[cnt];
        bus.busy    = 1'b1;
        cnt_en      = 1'b1;
      end
      ST_CAPTURE: begin
        bus.busy = 1'b1;
        cnt_clr  = 1'b1;
      end
      ST_UNLOAD: begin
        bus.scan_en = 1'b1;
        bus.busy    = 1'b1;
        cnt_en      = 1'b1;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        cnt_clr  = 1'b1;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Test-vector latch, response shifter and result registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vec_q      <= '0;
      resp_sh_q  <= '0;
      response_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      if (accept_c) begin
        vec_q      <= '{pattern: bus.pattern, expected: bus.expected};
        response_q <= '0;
        pass_q     <= 1'b0;
      end
      if (state_q == ST_UNLOAD) begin
        resp_sh_q <= resp_next_c[N-1:1];
      end
      if (unload_last_c) begin
        response_q <= resp_next_c;
        pass_q     <= (resp_next_c == vec_q.expected);
      end
    end
  end

  assign bus.response = response_q;
  assign bus.pass     = pass_q;

`ifdef SCAN_FAIL_CNT_EN
  logic [FAIL_CNT_W-1:0] fail_cnt_q;

  // Counts failing tests, saturating; only reset clears it
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fail_cnt_q <= '0;
    end else if (unload_last_c && (resp_next_c != vec_q.expected) && (fail_cnt_q != '1)) begin
      fail_cnt_q <= fail_cnt_q + FAIL_CNT_W'(1);
    end
  end

  assign bus.fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench: controller driving a behavioural 8-flop scan chain wrapped around a 4x4 multiplier.
module tb_scan_test_controller;

  logic clk;
  logic rst_n;
  logic [7:0] chain = '0;
  int n_assert = 0;
  int n_fail   = 0;
  int model_fail_cnt = 0;

  scan_test_controller_if bus ();

  scan_test_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain: head dff[7] takes scan_in, tail dff[0] feeds scan_out; capture loads a*b
  assign bus.scan_out = chain[0];
  always @(posedge clk) begin
    if (bus.scan_en) chain <= {bus.scan_in, chain[7:1]};
    else             chain <= {4'b0, chain[7:4]} * {4'b0, chain[3:0]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_fail_cnt(input string tag);
`ifdef SCAN_FAIL_CNT_EN
    check({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 32'(model_fail_cnt));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // One complete test from an idle controller; optional stray start at cycle ignore_at
  task automatic do_test(input logic [7:0] pat, input logic [7:0] exp_v,
                         input int ignore_at, input string tag);
    logic [7:0] model_resp;
    logic       model_pass;
    logic       exp_en;
    logic       exp_in;
    int         seq_bad;
    int         n_done;
    model_resp = {4'b0, pat[7:4]} * {4'b0, pat[3:0]};
    model_pass = (model_resp == exp_v);
    seq_bad    = 0;
    n_done     = 0;
    bus.pattern  = pat;
    bus.expected = exp_v;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.pattern  = ~pat;
    bus.expected = ~exp_v;
    check({tag, "_clr_resp"}, 32'(bus.response), 32'h0);
    check({tag, "_clr_pass"}, 32'(bus.pass), 32'h0);
    for (int cyc = 1; cyc <= 22; cyc++) begin
      exp_en = ((cyc >= 1) && (cyc <= 8)) || ((cyc >= 10) && (cyc <= 17));
      exp_in = 1'b0;
      if (cyc <= 8) exp_in = pat[cyc-1];
      if (bus.done === 1'b1) n_done++;
      if ((bus.scan_en !== exp_en) || (bus.scan_in !== exp_in) ||
          (bus.busy !== (cyc <= 17)) || (bus.done !== (cyc == 18)))
        seq_bad++;
      if (cyc == ignore_at) begin
        bus.pattern = 8'h22;
        bus.start   = 1'b1;
      end
      tick();
      bus.start = 1'b0;
    end
    if (!model_pass && model_fail_cnt < 255) model_fail_cnt++;
    check({tag, "_seq"}, 32'(seq_bad), 32'h0);
    check({tag, "_n_done"}, 32'(n_done), 32'h1);
    check({tag, "_response"}, 32'(bus.response), 32'(model_resp));
    check({tag, "_pass"}, 32'(bus.pass), 32'(model_pass));
    check_fail_cnt(tag);
  endtask

  initial begin
    logic [7:0] rp;
    logic [7:0] re;
    bus.start    = 1'b0;
    bus.pattern  = '0;
    bus.expected = '0;
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    check("rst_busy",     32'(bus.busy),     32'h0);
    check("rst_done",     32'(bus.done),     32'h0);
    check("rst_pass",     32'(bus.pass),     32'h0);
    check("rst_response", 32'(bus.response), 32'h0);
    check("rst_scan_en",  32'(bus.scan_en),  32'h0);
    check("rst_scan_in",  32'(bus.scan_in),  32'h0);
    check_fail_cnt("rst");

    do_test(8'h35, 8'h0F, 0, "basic");
    do_test(8'hFF, 8'hE1, 0, "max");
    do_test(8'h35, 8'h10, 0, "mismatch");
    do_test(8'h35, 8'h0F, 5, "busy_ignore");

    // Reset in the middle of LOAD
    bus.pattern  = 8'h35;
    bus.expected = 8'h0F;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    model_fail_cnt = 0;
    check("midrst_busy",    32'(bus.busy),    32'h0);
    check("midrst_scan_en", 32'(bus.scan_en), 32'h0);
    tick();
    rst_n = 1'b0;
    check("midrst_pass",     32'(bus.pass),     32'h0);
    check("midrst_response", 32'(bus.response), 32'h0);
    check_fail_cnt("midrst");
    tick();
    do_test(8'h35, 8'h0F, 0, "after_rst");

    for (int i = 0; i < 16; i++) begin
      rp = 8'($urandom);
      re = 8'($urandom);
      if ($urandom_range(0, 1) == 1) re = {4'b0, rp[7:4]} * {4'b0, rp[3:0]};
      do_test(rp, re, 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
